// File: rtl/cpu_dma_rx_pkt_writer_pkg.sv
// Shared definitions for the CPU DMA receive packet writer: FSM encoding,
// last-word ctrl codes and the byte-to-word helper.
package cpu_dma_rx_pkt_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_TERM = 2'd3
  } state_t;

  localparam logic [3:0] CTRL_LAST_4B = 4'h8;
  localparam logic [3:0] CTRL_LAST_3B = 4'h4;
  localparam logic [3:0] CTRL_LAST_2B = 4'h2;
  localparam logic [3:0] CTRL_LAST_1B = 4'h1;

  localparam int CDQ_MAX_PKT_BYTES = 2048;

  function automatic logic [9:0] bytes_to_words(input logic [11:0] len);
    logic [12:0] w_sum;
    w_sum = {1'b0, len} + 13'd3;
    return w_sum[11:2];
  endfunction

  // len[1:0] of zero means the last word carries all four bytes
  function automatic logic [3:0] last_ctrl(input logic [1:0] last_bytes);
    case (last_bytes)
      2'd1:    return CTRL_LAST_1B;
      2'd2:    return CTRL_LAST_2B;
      2'd3:    return CTRL_LAST_3B;
      default: return CTRL_LAST_4B;
    endcase
  endfunction

endpackage

// File: rtl/cdq_timeout_ctr.sv
// Clear/enable counter that pulses o_tc on the cycle its count would reach LIMIT.
module cdq_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  assign o_tc = i_en && !i_clr && (r_cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/cpu_dma_rx_pkt_writer.sv
// Converts CPCI DMA packet transfers into CPU DMA queue writes (length word,
// data words, last-word ctrl). Stats counters built only with CPU_DMA_RX_STATS_EN.
module cpu_dma_rx_pkt_writer
  import cpu_dma_rx_pkt_writer_pkg::*;
#(
  parameter int DMA_DATA_WIDTH = 32,
  parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
  parameter int MAX_PKT_BYTES  = CDQ_MAX_PKT_BYTES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dma_xfer_req,
  input  logic [11:0]               dma_xfer_len,
  output logic                      dma_xfer_ack,
  output logic                      dma_xfer_err,
  input  logic                      dma_data_vld,
  input  logic [DMA_DATA_WIDTH-1:0] dma_data,
  output logic                      dma_data_rdy,
  input  logic                      cpu_q_dma_nearly_full,
  input  logic                      cpu_q_dma_can_wr_pkt,
  output logic                      cpu_q_dma_wr,
  output logic                      cpu_q_dma_wr_pkt_vld,
  output logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_wr_data,
  output logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_wr_ctrl,
  output logic [15:0]               timeout_cnt,
  output logic [15:0]               pkt_cnt
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [11:0]               r_len;
  logic [9:0]                r_words_left;
  logic [1:0]                r_last_bytes;
  logic                      r_ack;
  logic                      r_err;
  logic                      r_wr;
  logic                      r_pkt_vld;
  logic [DMA_DATA_WIDTH-1:0] r_wr_data;
  logic [DMA_CTRL_WIDTH-1:0] r_wr_ctrl;

  logic                      w_rdy;
  logic                      w_accept;
  logic                      w_len_bad;
  logic                      w_ack;
  logic                      w_err;
  logic                      w_load;
  logic                      w_wr;
  logic                      w_pvld;
  logic                      w_dec;
  logic [DMA_DATA_WIDTH-1:0] w_data;
  logic [DMA_CTRL_WIDTH-1:0] w_ctrl;
  logic                      w_pkt_inc;
  logic                      w_to_inc;
  logic                      w_to_en;
  logic                      w_to_clr;
  logic                      w_to_tc;

  assign w_rdy     = (r_state == ST_DATA) && !cpu_q_dma_nearly_full;
  assign w_accept  = dma_data_vld && w_rdy;
  assign w_len_bad = (dma_xfer_len == 12'd0) ||
                     ({1'b0, dma_xfer_len} > 13'(MAX_PKT_BYTES));

  // Starvation only counts while the queue is willing to take data
  assign w_to_en  = (r_state == ST_DATA) && w_rdy && !dma_data_vld;
  assign w_to_clr = (r_state != ST_DATA) || w_accept;

  cdq_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (reset),
    .i_clr (w_to_clr),
    .i_en  (w_to_en),
    .o_tc  (w_to_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_load      = 1'b0;
    w_wr        = 1'b0;
    w_pvld      = 1'b0;
    w_dec       = 1'b0;
    w_data      = '0;
    w_ctrl      = '0;
    w_pkt_inc   = 1'b0;
    w_to_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_err masks the still-held req in the cycle the err pulse is visible
        if (dma_xfer_req && !r_err) begin
          if (w_len_bad) begin
            w_err = 1'b1;
          end else if (cpu_q_dma_can_wr_pkt) begin
            w_ack       = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (!cpu_q_dma_nearly_full) begin
          w_wr        = 1'b1;
          w_data      = {{(DMA_DATA_WIDTH - 12){1'b0}}, r_len};
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_wr   = 1'b1;
          w_data = dma_data;
          w_dec  = 1'b1;
          if (r_words_left == 10'd1) begin
            w_ctrl      = DMA_CTRL_WIDTH'(last_ctrl(r_last_bytes));
            w_pvld      = 1'b1;
            w_pkt_inc   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_to_tc) begin
          w_state_nxt = ST_TERM;
        end
      end
      ST_TERM: begin
        if (!cpu_q_dma_nearly_full) begin
          w_wr        = 1'b1;
          w_ctrl      = DMA_CTRL_WIDTH'(CTRL_LAST_4B);
          w_to_inc    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_wr         <= 1'b0;
      r_pkt_vld    <= 1'b0;
      r_wr_data    <= '0;
      r_wr_ctrl    <= '0;
      r_len        <= '0;
      r_words_left <= '0;
      r_last_bytes <= '0;
    end else begin
      r_ack     <= w_ack;
      r_err     <= w_err;
      r_wr      <= w_wr;
      r_pkt_vld <= w_pvld;
      r_wr_ctrl <= w_ctrl;
      if (w_wr) begin
        r_wr_data <= w_data;
      end
      if (w_load) begin
        r_len        <= dma_xfer_len;
        r_words_left <= bytes_to_words(dma_xfer_len);
        r_last_bytes <= dma_xfer_len[1:0];
      end else if (w_dec) begin
        r_words_left <= r_words_left - 10'd1;
      end
    end
  end

  assign dma_xfer_ack         = r_ack;
  assign dma_xfer_err         = r_err;
  assign dma_data_rdy         = w_rdy;
  assign cpu_q_dma_wr         = r_wr;
  assign cpu_q_dma_wr_pkt_vld = r_pkt_vld;
  assign cpu_q_dma_wr_data    = r_wr_data;
  assign cpu_q_dma_wr_ctrl    = r_wr_ctrl;

`ifdef CPU_DMA_RX_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_timeout_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_cnt     <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (w_pkt_inc && (r_pkt_cnt != 16'hFFFF)) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_to_inc && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end
    end
  end

  assign pkt_cnt     = r_pkt_cnt;
  assign timeout_cnt = r_timeout_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_pkt_inc | w_to_inc;
  assign pkt_cnt        = '0;
  assign timeout_cnt    = '0;
`endif

endmodule
